// File: rtl/div_pkg.sv
// div_pkg: shared defaults, entry layout and drop-counter limit for the divider operand FIFO.
package div_pkg;
  localparam int M_DEF = 3;
  localparam int N_DEF = 2;
  localparam int DEPTH_DEF = 4;
  localparam int DBZ_DROP_MAX = 255;
  typedef struct packed {
    logic [M_DEF-1:0] a;
    logic [N_DEF-1:0] b;
    logic             dbz;
  } div_entry_t;
endpackage

// File: rtl/div_fifo_mem.sv
// div_fifo_mem: DEPTH x W register array, synchronous write, asynchronous read.
module div_fifo_mem
  import div_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W = $bits(div_entry_t),
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/div_operand_fifo.sv
// div_operand_fifo: valid/ready operand FIFO in front of the unsigned divider.
// Define DIV_OPFIFO_DBZ_FILTER_EN to drop zero-divisor pairs and count them on dbz_drops.
module div_operand_fifo
  import div_pkg::*;
#(
  parameter int M = M_DEF,
  parameter int N = N_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [M-1:0]             in_a,
  input  logic [N-1:0]             in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [M-1:0]             out_a,
  output logic [N-1:0]             out_b,
  output logic                     out_dbz,
`ifdef DIV_OPFIFO_DBZ_FILTER_EN
  output logic [7:0]               dbz_drops,
`endif
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int W = M + N + 1;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop, in_dbz, wr_en;
  logic [W-1:0]  rdata;
  assign in_ready  = count_q != CW'(DEPTH);
  assign out_valid = count_q != '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign in_dbz    = in_b == '0;
`ifdef DIV_OPFIFO_DBZ_FILTER_EN
  logic [7:0] drops_q, drops_d;
  assign wr_en     = push && !in_dbz;
  assign drops_d   = (push && in_dbz && drops_q != 8'(DBZ_DROP_MAX)) ? drops_q + 8'd1 : drops_q;
  assign dbz_drops = drops_q;
  assign out_dbz   = 1'b0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) drops_q <= '0;
    else drops_q <= drops_d;
`else
  assign wr_en   = push;
  assign out_dbz = out_valid && rdata[0];
`endif
  assign wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
  assign rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
  assign count_d  = count_q + CW'(wr_en) - CW'(pop);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  div_fifo_mem #(.DEPTH(DEPTH), .W(W), .AW(AW)) u_mem (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i ({in_a, in_b, in_dbz}),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );
  // Head is forced to zero while empty so reset and idle outputs are clean.
  assign out_a = out_valid ? rdata[W-1 -: M] : '0;
  assign out_b = out_valid ? rdata[N:1] : '0;
  assign count = count_q;
endmodule

// File: tb/tb_div_operand_fifo.sv
// tb_div_operand_fifo: randomized and directed checks against a queue-based model.
module tb_div_operand_fifo;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [2:0] in_a = 0;
  logic [1:0] in_b = 0;
  logic in_ready, out_valid, out_dbz;
  logic [2:0] out_a;
  logic [1:0] out_b;
  logic [2:0] count;
  int total = 0, bad = 0;
  int drops = 0;
  logic [4:0] q[$];
`ifdef DIV_OPFIFO_DBZ_FILTER_EN
  logic [7:0] dbz_drops;
  localparam bit FILT = 1;
`else
  localparam bit FILT = 0;
`endif
  always #5 clk = ~clk;
  div_operand_fifo #(.M(3), .N(2), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_dbz(out_dbz),
`ifdef DIV_OPFIFO_DBZ_FILTER_EN
    .dbz_drops(dbz_drops),
`endif
    .count(count)
  );
  task automatic cyc(input logic v, input logic [2:0] a, input logic [1:0] b, input logic r);
    bit pu, po;
    in_valid = v; in_a = a; in_b = b; out_ready = r;
    pu = v && q.size() < 4;
    po = r && q.size() > 0;
    @(posedge clk);
    if (po) void'(q.pop_front());
    if (pu && FILT && b == 0) drops = drops < 255 ? drops + 1 : 255;
    else if (pu) q.push_back({a, b});
    #1;
    in_valid = 0; out_ready = 0;
  endtask
  task automatic test_reset;
    total++; if (in_ready !== 1) begin bad++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
    total++; if (out_valid !== 0) begin bad++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
    total++; if (count !== 0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
    total++; if ({out_a, out_b, out_dbz} !== 0) begin bad++; $display("FAIL rst_head got=%0h exp=0", {out_a, out_b, out_dbz}); end
`ifdef DIV_OPFIFO_DBZ_FILTER_EN
    total++; if (dbz_drops !== 0) begin bad++; $display("FAIL rst_drops got=%0d exp=0", dbz_drops); end
`endif
  endtask
  task automatic test_basic;
    cyc(1, 5, 2, 0);
    total++; if (out_valid !== 1) begin bad++; $display("FAIL basic_valid got=%0b exp=1", out_valid); end
    total++; if (out_a !== 5 || out_b !== 2) begin bad++; $display("FAIL basic_head got=%0d/%0d exp=5/2", out_a, out_b); end
    total++; if (out_dbz !== 0) begin bad++; $display("FAIL basic_dbz got=%0b exp=0", out_dbz); end
    total++; if (count !== 1) begin bad++; $display("FAIL basic_count got=%0d exp=1", count); end
    cyc(0, 0, 0, 1);
  endtask
  task automatic test_full;
    logic [2:0] av [4] = '{1, 6, 3, 7};
    logic [1:0] bv [4] = '{3, 1, 2, 1};
    for (int i = 0; i < 4; i++) begin
      cyc(1, av[i], bv[i], 0);
      total++; if (out_a !== 1 || out_b !== 3) begin bad++; $display("FAIL full_head_stable got=%0d/%0d exp=1/3", out_a, out_b); end
    end
    total++; if (count !== 4) begin bad++; $display("FAIL full_count got=%0d exp=4", count); end
    total++; if (in_ready !== 0) begin bad++; $display("FAIL full_ready got=%0b exp=0", in_ready); end
    cyc(1, 2, 2, 0);
    total++; if (count !== 4) begin bad++; $display("FAIL full_5th got=%0d exp=4", count); end
    for (int i = 0; i < 4; i++) begin
      total++; if (out_a !== av[i] || out_b !== bv[i]) begin bad++; $display("FAIL full_pop%0d got=%0d/%0d exp=%0d/%0d", i, out_a, out_b, av[i], bv[i]); end
      cyc(0, 0, 0, 1);
    end
    total++; if (out_valid !== 0) begin bad++; $display("FAIL full_drain got=%0b exp=0", out_valid); end
  endtask
  task automatic test_wrap;
    for (int i = 0; i < 3; i++) cyc(1, 3'(i + 1), 2'(i + 1), 0);
    for (int i = 0; i < 10; i++) begin
      total++; if ({out_a, out_b} !== q[0]) begin bad++; $display("FAIL wrap_head got=%0h exp=%0h", {out_a, out_b}, q[0]); end
      cyc(1, 3'($urandom), 2'($urandom_range(1, 3)), 1);
      total++; if (count !== 3) begin bad++; $display("FAIL wrap_count got=%0d exp=3", count); end
    end
    cyc(1, 4, 1, 0);
    total++; if (count !== 4) begin bad++; $display("FAIL simul_fill got=%0d exp=4", count); end
    cyc(1, 6, 3, 1);
    total++; if (count !== 3) begin bad++; $display("FAIL simul_full_pop got=%0d exp=3", count); end
    while (q.size() > 0) cyc(0, 0, 0, 1);
  endtask
  task automatic test_dbz;
    cyc(1, 7, 0, 0);
    if (FILT) begin
      total++; if (count !== 0) begin bad++; $display("FAIL dbz_count got=%0d exp=0", count); end
`ifdef DIV_OPFIFO_DBZ_FILTER_EN
      total++; if (dbz_drops !== 8'(drops)) begin bad++; $display("FAIL dbz_drops1 got=%0d exp=%0d", dbz_drops, drops); end
      for (int i = 0; i < 299; i++) cyc(1, 7, 0, 0);
      total++; if (dbz_drops !== 8'd255) begin bad++; $display("FAIL dbz_sat got=%0d exp=255", dbz_drops); end
`endif
    end else begin
      total++; if (out_dbz !== 1 || out_a !== 7) begin bad++; $display("FAIL dbz_flag got=%0b/%0d exp=1/7", out_dbz, out_a); end
      cyc(0, 0, 0, 1);
    end
  endtask
  task automatic test_random;
    for (int i = 0; i < 300; i++) begin
      cyc($urandom_range(0, 3) != 0, 3'($urandom), 2'($urandom), $urandom_range(0, 2) != 0);
      total++;
      if (count !== 3'(q.size()) || in_ready !== (q.size() < 4) || out_valid !== (q.size() > 0) ||
          (q.size() > 0 && ({out_a, out_b} !== q[0] || out_dbz !== (!FILT && q[0][1:0] == 0)))) begin
        bad++;
        $display("FAIL rand%0d got cnt=%0d rdy=%0b v=%0b head=%0h dbz=%0b exp cnt=%0d head=%0h",
                 i, count, in_ready, out_valid, {out_a, out_b}, out_dbz, q.size(), q.size() > 0 ? q[0] : 5'd0);
      end
    end
  endtask
  task automatic test_async_reset;
    while (q.size() > 0) cyc(0, 0, 0, 1);
    cyc(1, 2, 1, 0);
    cyc(1, 3, 2, 0);
    #2 rst_n = 0;
    #1;
    q.delete();
    total++; if (out_valid !== 0) begin bad++; $display("FAIL arst_valid got=%0b exp=0", out_valid); end
    total++; if (count !== 0) begin bad++; $display("FAIL arst_count got=%0d exp=0", count); end
    total++; if (in_ready !== 1) begin bad++; $display("FAIL arst_ready got=%0b exp=1", in_ready); end
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    cyc(1, 6, 1, 0);
    total++; if (out_a !== 6 || count !== 1) begin bad++; $display("FAIL arst_after got=%0d/%0d exp=6/1", out_a, count); end
  endtask
  initial begin
    #12;
    test_reset;
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    test_basic;
    test_full;
    test_wrap;
    test_dbz;
    test_random;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
